// File: rtl/lmsm_sequencer_if.sv
// Bundle of the LM/SM sequencer's decode-stage and micro-op signals.
//   slave  : seen from the sequencer (ID inputs in, micro-op/stall outputs out)
//   master : seen from the surrounding pipeline / testbench
// Signals:
//   valid_id, opcode_id[3:0], imm8_id[7:0], base_id[15:0], stall_in, flush  (to sequencer)
//   stall_fetch, kill_id, busy, seq_valid, seq_is_load, seq_reg[2:0],
//   seq_addr[15:0], seq_last, uop_count[15:0]                               (from sequencer)
interface lmsm_sequencer_if;
  logic        valid_id;
  logic [3:0]  opcode_id;
  logic [7:0]  imm8_id;
  logic [15:0] base_id;
  logic        stall_in;
  logic        flush;
  logic        stall_fetch;
  logic        kill_id;
  logic        busy;
  logic        seq_valid;
  logic        seq_is_load;
  logic [2:0]  seq_reg;
  logic [15:0] seq_addr;
  logic        seq_last;
  logic [15:0] uop_count;

  modport slave (
    input  valid_id, opcode_id, imm8_id, base_id, stall_in, flush,
    output stall_fetch, kill_id, busy, seq_valid, seq_is_load, seq_reg, seq_addr,
           seq_last, uop_count
  );

  modport master (
    output valid_id, opcode_id, imm8_id, base_id, stall_in, flush,
    input  stall_fetch, kill_id, busy, seq_valid, seq_is_load, seq_reg, seq_addr,
           seq_last, uop_count
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer for the decode stage of the pipelined IITB-RISC core.
// Captures an LM/SM instruction in ID, kills it, and expands its 8-bit register
// mask into one LW/SW-type micro-op per unstalled cycle (R0 first, ascending
// word addresses from the base). Holds PC and IF/ID while the sequence runs.
// Ports:
//   clk   : pipeline clock
//   rst_n : synchronous active-low reset
//   bus   : lmsm_sequencer_if.slave (ID inputs, stall/flush, micro-op outputs)
// Optional feature: define LMSM_PERF_CNT_EN to build the issued-micro-op counter
// (uop_count); otherwise uop_count is tied to zero.
module lmsm_sequencer #(
  parameter logic [3:0] OPC_LM = 4'b0110,
  parameter logic [3:0] OPC_SM = 4'b0111
) (
  input logic               clk,
  input logic               rst_n,
  lmsm_sequencer_if.slave   bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic [15:0] addr_q, addr_d;
  logic        is_load_q, is_load_d;

  logic        is_lmsm;
  logic        accept;
  logic        issue;
  logic        in_run;
  logic [2:0]  lsb_idx;
  logic [7:0]  mask_rest;
  logic        last_bit;

  assign in_run  = (state_q == StRun);
  assign is_lmsm = (bus.opcode_id == OPC_LM) || (bus.opcode_id == OPC_SM);
  assign accept  = (state_q == StIdle) && bus.valid_id && is_lmsm && !bus.stall_in &&
                   !bus.flush;
  assign issue   = in_run && !bus.stall_in && !bus.flush;

  // Lowest set bit of the remaining mask; scanning downward leaves the lowest.
  always_comb begin
    lsb_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) lsb_idx = 3'(i);
    end
  end

  // Clearing the lowest set bit: x & (x - 1).
  assign mask_rest = mask_q & (mask_q - 8'd1);
  assign last_bit  = (mask_rest == 8'd0);

  always_comb begin
    bus.seq_valid   = issue;
    bus.seq_is_load = issue ? is_load_q : 1'b0;
    bus.seq_reg     = issue ? lsb_idx : 3'd0;
    bus.seq_addr    = issue ? addr_q : 16'd0;
    bus.seq_last    = issue && last_bit;
    bus.kill_id     = accept;
    bus.busy        = in_run;
    // A stalled RUN cycle is already covered by the "not issuing last" term.
    bus.stall_fetch = !bus.flush &&
                      ((accept && (bus.imm8_id != 8'd0)) || (in_run && !(issue && last_bit)));
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    addr_d    = addr_q;
    is_load_d = is_load_q;
    if (bus.flush) begin
      state_d = StIdle;
      mask_d  = 8'd0;
    end else if (accept) begin
      mask_d    = bus.imm8_id;
      addr_d    = bus.base_id;
      is_load_d = (bus.opcode_id == OPC_LM);
      state_d   = (bus.imm8_id != 8'd0) ? StRun : StIdle;
    end else if (issue) begin
      mask_d  = mask_rest;
      addr_d  = addr_q + 16'd1;
      state_d = last_bit ? StIdle : StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mask_q    <= 8'd0;
      addr_q    <= 16'd0;
      is_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      is_load_q <= is_load_d;
    end
  end

`ifdef LMSM_PERF_CNT_EN
  logic [15:0] uop_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uop_count_q <= 16'd0;
    end else if (issue) begin
      uop_count_q <= uop_count_q + 16'd1;
    end
  end

  assign bus.uop_count = uop_count_q;
`else
  assign bus.uop_count = 16'h0000;
`endif

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Micro-op sequencer for the LM/SM (load/store multiple) instructions of the pipelined IITB-RISC core. It sits in the decode stage. It captures an LM/SM instruction leaving ID and expands its 8-bit register mask into one single-register load/store micro-op per cycle. Each micro-op then flows through EX, MEM and the MEM/WB register like an ordinary LW/SW. While a sequence is running it holds the PC and the IF/ID register.

## Interface
Parameters:
- OPC_LM, 4'b0110, opcode of load-multiple
- OPC_SM, 4'b0111, opcode of store-multiple

Ports:
- clk  in  1  pipeline clock; all state changes on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- valid_id  in  1  ID stage holds a valid instruction
- opcode_id  in  4  opcode of the ID instruction
- imm8_id  in  8  register mask; bit i selects Ri
- base_id  in  16  value of Ra (base address), already forwarded
- stall_in  in  1  downstream hazard stall; freezes the sequencer
- flush  in  1  taken branch/jump in a later stage; aborts the sequence
- stall_fetch  out  1  hold PC and IF/ID (combinational)
- kill_id  out  1  replace the ID instruction with a bubble (combinational)
- busy  out  1  sequence in progress (registered)
- seq_valid  out  1  micro-op valid this cycle
- seq_is_load  out  1  1 = LW-type micro-op, 0 = SW-type
- seq_reg  out  3  register index of the micro-op
- seq_addr  out  16  memory word address of the micro-op
- seq_last  out  1  final micro-op of the sequence
- uop_count  out  16  issued-micro-op counter (see Configuration)

## Operation
- States: IDLE, RUN.
- Accept condition: state IDLE, valid_id=1, opcode_id ∈ {OPC_LM, OPC_SM}, stall_in=0, flush=0.
- On accept:
  - latch mask=imm8_id, addr=base_id, is_load=(opcode_id==OPC_LM);
  - assert kill_id=1, so the macro-instruction itself never proceeds;
  - go to RUN if mask≠0.
- Zero mask: accept still asserts kill_id, but state stays IDLE and nothing is issued. The instruction becomes a NOP.
- Each RUN cycle with stall_in=0 and flush=0:
  - seq_valid=1;
  - seq_reg = index of the lowest set bit of mask (R0 first);
  - seq_addr = addr;
  - next state: that bit is cleared and addr ← addr+1, modulo 2^16 (wraps FFFF→0000).
- seq_last=1 when the issuing bit is the only remaining set bit. The next state is then IDLE.
- stall_fetch = (accept and mask has ≥1 set bit) OR (RUN and not the cycle issuing seq_last) OR (RUN and stall_in).
- Stall: stall_in=1 in RUN gives seq_valid=0. Mask, addr and state are held.
- Flush: flush=1 has priority over everything:
  - seq_valid=0, kill_id=0, stall_fetch=0;
  - next state IDLE, mask cleared.
- The outputs seq_is_load/seq_reg/seq_addr are don't-care when seq_valid=0; drive 0.
- Accept is impossible while in RUN. A second LM/SM simply waits in ID under stall_fetch.

## Timing
- Reset (rst_n=0 at a posedge) gives state IDLE, mask=0, addr=0, busy=0, uop_count=0. All combinational outputs then evaluate to 0.
- Reset mid-sequence aborts immediately. No further micro-ops are issued.
- Latency: the first micro-op is issued in the cycle after accept.
- Throughput: N set bits produce N micro-ops in N unstalled cycles.
- Fetch: the PC resumes in the same cycle seq_last is issued, so the next instruction enters ID one cycle later.
- busy is high from the cycle after accept through the cycle issuing seq_last.
- Simultaneous stall_in and flush: flush wins.

## Configuration
- LMSM_PERF_CNT_EN defined:
  - uop_count increments by 1 on every cycle with seq_valid=1;
  - it wraps at 16 bits and is cleared only by reset.
- LMSM_PERF_CNT_EN undefined: uop_count is tied to 16'h0000 and there is no counter register.

## Test plan
- LM, imm8=8'b1000_0101, base=0x0040 → micro-ops (R0,0x0040), (R2,0x0041), (R7,0x0042 with seq_last=1), seq_is_load=1. stall_fetch high on the accept cycle and the first two RUN cycles.
- SM, imm8=8'h00 → kill_id pulses one cycle, busy stays 0, no seq_valid, stall_fetch never high.
- SM, imm8=8'hFF, base=0xFFFE → 8 micro-ops R0..R7 with addresses FFFE, FFFF, 0000…0005, seq_is_load=0.
- LM, imm8=8'h0F, stall_in high for 2 cycles after the second micro-op → R2 held; sequence completes in 6 cycles after accept, with no duplicate or skipped register.
- LM, imm8=8'hF0, flush on the second RUN cycle → only R4 issued, IDLE the next cycle; rst_n low mid-sequence gives the same abort, with uop_count reset.
- With LMSM_PERF_CNT_EN: the two sequences from the first and third scenarios give uop_count=11. Without it, uop_count stays 0.
